// File: rtl/hdu_pkg.sv
// Shared constants for the hazard-detection unit: mode encoding, hazard codes
// and push-button bit positions.
package hdu_pkg;

   typedef enum logic [2:0] {
      MODE_IDLE    = 3'd0,
      MODE_INPUT   = 3'd1,
      MODE_CHECK   = 3'd2,
      MODE_DISPLAY = 3'd3,
      MODE_CLEAR   = 3'd4
   } mode_t;

   localparam logic [1:0] HZ_NONE = 2'd0;
   localparam logic [1:0] HZ_RAW1 = 2'd1;
   localparam logic [1:0] HZ_RAW2 = 2'd2;
   localparam logic [1:0] HZ_LOAD = 2'd3;

   localparam int BTN_INPUT = 0;
   localparam int BTN_CHECK = 1;
   localparam int BTN_DISP  = 2;
   localparam int BTN_CLEAR = 3;

endpackage

// File: rtl/hdu_btn_edge.sv
// One push-button: multi-flop synchronizer followed by a rising-edge detector
// that emits a single-cycle pulse per press, however long it is held.
module hdu_btn_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   logic [STAGES-1:0] sync_r;
   logic              prev_r;

   // Synchronizer chain and previous-level flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= {STAGES{1'b0}};
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[STAGES-2:0], btn};
         prev_r <= sync_r[STAGES-1];
      end
   end

   assign pulse = sync_r[STAGES-1] & ~prev_r;

endmodule

// File: rtl/hdu_mode_ctrl.sv
// Mode sequencer for the hazard-detection unit: button commands drive the
// input, check, display and clear phases over the instruction/hazard memories.
module hdu_mode_ctrl
   import hdu_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    btn_in,
   input  logic [7:0]    instr_in,
   input  logic          instr_valid,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [7:0]    imem_wdata,
   output logic          chk_req,
   output logic [AW-1:0] chk_idx,
   input  logic          chk_done,
   input  logic [1:0]    chk_hazard,
   output logic          hmem_we,
   output logic [AW-1:0] hmem_addr,
   output logic [1:0]    hmem_wdata,
   output logic [AW-1:0] disp_addr,
   output logic          disp_valid,
   output logic [2:0]    mode,
   output logic [AW:0]   instr_count,
   output logic          full,
   output logic          busy
);

   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_A  = (AW)'(DEPTH - 1);
   localparam logic [AW:0]   ONE_C   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   TWO_C   = {{(AW-1){1'b0}}, 2'b10};
   localparam logic [AW-1:0] ONE_A   = {{(AW-1){1'b0}}, 1'b1};

   mode_t         state_r, state_s;
   logic [AW:0]   count_r, count_s;
   logic          checked_r, checked_s;
   logic [AW-1:0] chk_idx_r, chk_idx_s;
   logic          chk_act_r, chk_act_s;
   logic [AW-1:0] disp_r, disp_s;
   logic [AW-1:0] clr_r, clr_s;
   logic [3:0]    pulse_s;
   logic [3:0]    cmd_s;
   logic          full_s;

   for (genvar i = 0; i < 4; i++) begin : g_btn
      hdu_btn_edge #(.STAGES(SYNC_STAGES)) u_edge (
         .clk   (clk),
         .rst_n (rst_n),
         .btn   (btn_in[i]),
         .pulse (pulse_s[i])
      );
   end

   // Same-cycle presses: clear beats input beats check beats display.
   always_comb begin
      cmd_s            = 4'b0000;
      cmd_s[BTN_CLEAR] = pulse_s[BTN_CLEAR];
      cmd_s[BTN_INPUT] = pulse_s[BTN_INPUT] & ~pulse_s[BTN_CLEAR];
      cmd_s[BTN_CHECK] = pulse_s[BTN_CHECK] & ~pulse_s[BTN_CLEAR] & ~pulse_s[BTN_INPUT];
      cmd_s[BTN_DISP]  = pulse_s[BTN_DISP] & ~pulse_s[BTN_CLEAR] & ~pulse_s[BTN_INPUT]
                       & ~pulse_s[BTN_CHECK];
   end

   assign full_s = (count_r == DEPTH_C);

   // Next-state and memory-port decode.
   always_comb begin
      state_s    = state_r;
      count_s    = count_r;
      checked_s  = checked_r;
      chk_idx_s  = chk_idx_r;
      chk_act_s  = chk_act_r;
      disp_s     = disp_r;
      clr_s      = clr_r;
      imem_we    = 1'b0;
      imem_addr  = {AW{1'b0}};
      imem_wdata = 8'h00;
      hmem_we    = 1'b0;
      hmem_addr  = {AW{1'b0}};
      hmem_wdata = HZ_NONE;
      chk_req    = 1'b0;
      case (state_r)
         MODE_IDLE: begin
            if (cmd_s[BTN_CLEAR]) begin
               state_s = MODE_CLEAR;
               clr_s   = {AW{1'b0}};
            end else if (cmd_s[BTN_INPUT]) begin
               state_s   = MODE_INPUT;
               count_s   = {(AW+1){1'b0}};
               checked_s = 1'b0;
            end else if (cmd_s[BTN_CHECK] && (count_r >= TWO_C)) begin
               state_s   = MODE_CHECK;
               chk_idx_s = ONE_A;
               chk_act_s = 1'b0;
            end else if (cmd_s[BTN_DISP] && checked_r) begin
               state_s = MODE_DISPLAY;
               disp_s  = {AW{1'b0}};
            end else begin
               state_s = MODE_IDLE;
            end
         end
         MODE_INPUT: begin
            if (instr_valid && !full_s) begin
               imem_we    = 1'b1;
               imem_addr  = count_r[AW-1:0];
               imem_wdata = instr_in;
               count_s    = count_r + ONE_C;
            end else begin
               count_s = count_r;
            end
            if (cmd_s[BTN_CLEAR]) begin
               state_s = MODE_CLEAR;
               clr_s   = {AW{1'b0}};
            end else if (cmd_s[BTN_INPUT]) begin
               state_s = MODE_IDLE;
            end else begin
               state_s = MODE_INPUT;
            end
         end
         MODE_CHECK: begin
            if (cmd_s[BTN_CLEAR]) begin
               state_s   = MODE_CLEAR;
               clr_s     = {AW{1'b0}};
               checked_s = 1'b0;
               chk_act_s = 1'b0;
            end else if (!chk_act_r) begin
               // Instruction 0 has no predecessor, so its result is fixed.
               hmem_we   = 1'b1;
               chk_act_s = 1'b1;
            end else begin
               chk_req = 1'b1;
               if (chk_done) begin
                  hmem_we    = 1'b1;
                  hmem_addr  = chk_idx_r;
                  hmem_wdata = chk_hazard;
                  if ({1'b0, chk_idx_r} == (count_r - ONE_C)) begin
                     checked_s = 1'b1;
                     chk_act_s = 1'b0;
                     state_s   = MODE_IDLE;
                  end else begin
                     chk_idx_s = chk_idx_r + ONE_A;
                  end
               end else begin
                  chk_idx_s = chk_idx_r;
               end
            end
         end
         MODE_DISPLAY: begin
            if (cmd_s[BTN_CLEAR]) begin
               state_s = MODE_CLEAR;
               clr_s   = {AW{1'b0}};
            end else if (cmd_s[BTN_INPUT]) begin
               state_s   = MODE_INPUT;
               checked_s = 1'b0;
            end else if (cmd_s[BTN_DISP]) begin
               if ({1'b0, disp_r} == (count_r - ONE_C)) begin
                  disp_s = {AW{1'b0}};
               end else begin
                  disp_s = disp_r + ONE_A;
               end
            end else begin
               state_s = MODE_DISPLAY;
            end
         end
         MODE_CLEAR: begin
            imem_we   = 1'b1;
            hmem_we   = 1'b1;
            imem_addr = clr_r;
            hmem_addr = clr_r;
            if (clr_r == LAST_A) begin
               state_s   = MODE_IDLE;
               count_s   = {(AW+1){1'b0}};
               checked_s = 1'b0;
               disp_s    = {AW{1'b0}};
            end else begin
               clr_s = clr_r + ONE_A;
            end
         end
         default: begin
            state_s = MODE_IDLE;
         end
      endcase
   end

   // State and bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= MODE_IDLE;
         count_r   <= {(AW+1){1'b0}};
         checked_r <= 1'b0;
         chk_idx_r <= {AW{1'b0}};
         chk_act_r <= 1'b0;
         disp_r    <= {AW{1'b0}};
         clr_r     <= {AW{1'b0}};
      end else begin
         state_r   <= state_s;
         count_r   <= count_s;
         checked_r <= checked_s;
         chk_idx_r <= chk_idx_s;
         chk_act_r <= chk_act_s;
         disp_r    <= disp_s;
         clr_r     <= clr_s;
      end
   end

   assign chk_idx     = chk_idx_r;
   assign disp_addr   = disp_r;
   assign disp_valid  = (state_r == MODE_DISPLAY);
   assign mode        = state_r;
   assign instr_count = count_r;
   assign full        = full_s;
   assign busy        = (state_r == MODE_CHECK) || (state_r == MODE_CLEAR);

endmodule

// File: tb/tb_hdu_mode_ctrl.sv
// Directed bench for hdu_mode_ctrl: memory writes go through an expected-write
// scoreboard, mode/handshake outputs are compared at fixed points.
module tb_hdu_mode_ctrl;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int SYNC  = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    btn_in;
   logic [7:0]    instr_in;
   logic          instr_valid;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [7:0]    imem_wdata;
   logic          chk_req;
   logic [AW-1:0] chk_idx;
   logic          chk_done;
   logic [1:0]    chk_hazard;
   logic          hmem_we;
   logic [AW-1:0] hmem_addr;
   logic [1:0]    hmem_wdata;
   logic [AW-1:0] disp_addr;
   logic          disp_valid;
   logic [2:0]    mode;
   logic [AW:0]   instr_count;
   logic          full;
   logic          busy;

   int tests = 0;
   int fails = 0;
   logic [31:0] imem_q[$];
   logic [31:0] hmem_q[$];

   hdu_mode_ctrl #(.DEPTH(DEPTH), .AW(AW), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .instr_in(instr_in),
      .instr_valid(instr_valid), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .chk_req(chk_req), .chk_idx(chk_idx),
      .chk_done(chk_done), .chk_hazard(chk_hazard), .hmem_we(hmem_we),
      .hmem_addr(hmem_addr), .hmem_wdata(hmem_wdata), .disp_addr(disp_addr),
      .disp_valid(disp_valid), .mode(mode), .instr_count(instr_count),
      .full(full), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gap();
      repeat (SYNC + 1) tick();
   endtask

   // Returns right after the edge on which the command takes effect.
   task automatic press(input logic [3:0] mask);
      btn_in = mask;
      repeat (SYNC + 1) tick();
      btn_in = 4'b0000;
   endtask

   function automatic logic [31:0] iw(input int a, input int d);
      return 32'h0001_0000 | (a << 8) | d;
   endfunction

   task automatic push_clear();
      for (int a = 0; a < DEPTH; a++) begin
         imem_q.push_back(iw(a, 0));
         hmem_q.push_back(iw(a, 0));
      end
   endtask

   task automatic answer(input int k, input logic [1:0] code);
      int n;
      n = 0;
      while (!chk_req && n < 20) begin
         tick();
         n++;
      end
      check("chk_req_wait", {31'd0, chk_req}, 32'd1);
      check("chk_idx", {28'd0, chk_idx}, k);
      repeat (3) begin
         tick();
         check("chk_idx_hold", {27'd0, chk_req, chk_idx}, 32'h10 | k);
      end
      chk_done   = 1'b1;
      chk_hazard = code;
      hmem_q.push_back(iw(k, code));
      tick();
      chk_done   = 1'b0;
      chk_hazard = 2'b00;
   endtask

   task automatic wait_idle_after_clear(input string tag);
      int n;
      n = 0;
      while (mode != 3'd0 && n < 40) begin
         tick();
         n++;
      end
      check(tag, n, DEPTH);
      check("count_after_clear", {27'd0, instr_count}, 32'd0);
   endtask

   // Every memory write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n && imem_we) begin
         e = 32'hDEAD_BEEF;
         if (imem_q.size() > 0) e = imem_q.pop_front();
         check("imem_write", 32'h0001_0000 | ({28'd0, imem_addr} << 8) | {24'd0, imem_wdata}, e);
      end
      if (rst_n && hmem_we) begin
         e = 32'hDEAD_BEEF;
         if (hmem_q.size() > 0) e = hmem_q.pop_front();
         check("hmem_write", 32'h0001_0000 | ({28'd0, hmem_addr} << 8) | {30'd0, hmem_wdata}, e);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; btn_in = 4'b0001; instr_in = 8'h00; instr_valid = 1'b0;
      chk_done = 1'b0; chk_hazard = 2'b00;
      repeat (3) tick();
      check("reset_outs", {imem_we, hmem_we, chk_req, disp_valid, full, busy, mode, instr_count},
            32'd0);
      check("reset_addrs", {chk_idx, disp_addr, imem_addr, hmem_addr}, 32'd0);

      // Button held through reset: one pulse, SYNC+1 cycles after release.
      rst_n = 1'b1;
      repeat (SYNC) tick();
      check("latency_early", {29'd0, mode}, 32'd0);
      tick();
      check("latency_mode", {29'd0, mode}, 32'd1);
      check("latency_count", {27'd0, instr_count}, 32'd0);
      repeat (5) tick();
      check("held_one_pulse", {29'd0, mode}, 32'd1);
      btn_in = 4'b0000;
      gap();

      // Fill past DEPTH: the 17th byte must not be written.
      for (int i = 0; i < 17; i++) begin
         instr_in = 8'(8'h10 + i);
         instr_valid = 1'b1;
         if (i < DEPTH) imem_q.push_back(iw(i, 8'h10 + i));
         tick();
      end
      instr_valid = 1'b0;
      check("full_flag", {31'd0, full}, 32'd1);
      check("full_count", {27'd0, instr_count}, 32'd16);
      press(4'b0001);
      check("input_exit", {29'd0, mode}, 32'd0);
      gap();

      // Four instructions then a full check run.
      press(4'b0001);
      check("reenter_count", {27'd0, instr_count}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         instr_in = 8'(8'h40 + i);
         instr_valid = 1'b1;
         imem_q.push_back(iw(i, 8'h40 + i));
         tick();
      end
      instr_valid = 1'b0;
      press(4'b0001);
      gap();
      hmem_q.push_back(iw(0, 0));
      press(4'b0010);
      check("check_mode", {29'd0, mode}, 32'd2);
      check("check_busy", {31'd0, busy}, 32'd1);
      answer(1, 2'd1);
      answer(2, 2'd0);
      answer(3, 2'd3);
      check("check_done", {28'd0, chk_req, mode}, 32'd0);
      chk_done = 1'b1;
      tick();
      chk_done = 1'b0;
      gap();

      // Abort a check with clear after the first result.
      hmem_q.push_back(iw(0, 0));
      press(4'b0010);
      answer(1, 2'd2);
      push_clear();
      press(4'b1000);
      check("abort_mode", {28'd0, chk_req, mode}, 32'd4);
      wait_idle_after_clear("clear_cycles");
      gap();

      // Three instructions, check, then browse the results.
      press(4'b0001);
      for (int i = 0; i < 3; i++) begin
         instr_in = 8'(8'hA1 + i);
         instr_valid = 1'b1;
         imem_q.push_back(iw(i, 8'hA1 + i));
         tick();
      end
      instr_valid = 1'b0;
      press(4'b0001);
      gap();
      hmem_q.push_back(iw(0, 0));
      press(4'b0010);
      answer(1, 2'd1);
      answer(2, 2'd3);
      gap();
      press(4'b0100);
      check("disp_entry", {24'd0, mode, disp_valid, disp_addr}, 32'h70);
      for (int j = 0; j < 5; j++) begin
         gap();
         press(4'b0100);
         check("disp_addr", {28'd0, disp_addr}, (j + 1) % 3);
      end
      gap();
      press(4'b0001);
      check("disp_exit", {24'd0, mode, disp_valid, disp_addr}, 32'h22);
      gap();
      press(4'b0001);
      gap();

      // Simultaneous input and clear: clear wins.
      push_clear();
      press(4'b1001);
      check("prio_clear", {29'd0, mode}, 32'd4);
      wait_idle_after_clear("prio_clear_cycles");
      gap();
      press(4'b0100);
      tick();
      check("disp_unchecked", {29'd0, mode}, 32'd0);
      gap();
      press(4'b0010);
      tick();
      check("check_too_few", {29'd0, mode}, 32'd0);
      gap();

      check("imem_q_empty", imem_q.size(), 32'd0);
      check("hmem_q_empty", hmem_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
